// File: rtl/steuerwerk_pkg.sv
// rtl/steuerwerk_pkg.sv - shared constants and types for the multicycle control unit
package steuerwerk_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    // Instruction field positions
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    // Flag register bit positions
    localparam int ZERO  = 0;
    localparam int CARRY = 1;

    // Opcodes; 0x0-0x7 are ALU operations, 0xC-0xE are NOPs
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic is_alu(input logic [3:0] op);
        return !op[3];
    endfunction

endpackage

// File: rtl/steuerwerk_mc_wait_timer.sv
// rtl/steuerwerk_mc_wait_timer.sv - handshake wait counter shared by FETCH and MEM
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear count (not waiting, or handshake seen)
//   en_i       : count one more cycle without handshake
//   expired_o  : this cycle is the last one allowed; no handshake now means timeout
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count reaches TIMEOUT at the coming edge if no handshake arrives now.
    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/steuerwerk_mc.sv
// rtl/steuerwerk_mc.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control unit
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   instr_req/addr/valid/data     : instruction fetch handshake
//   addr1, addr2, addrdest        : register bank read/write addresses
//   reg_we, wb_sel                : write strobe and write-back source
//   alu_ctrl, status              : ALU operation and {carry, zero} flags
//   mem_req, mem_rnw, mem_ack     : memory-manager handshake
//   halted, err                   : core stopped, stopped by timeout
module steuerwerk_mc
    import steuerwerk_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int REG_CNT = 8,
    parameter  int PC_W    = 8,
    parameter  int INSTR_W = 16,
    parameter  int TIMEOUT = 15,
    localparam int REG_AW  = $clog2(REG_CNT)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               instr_req,
    output logic [PC_W-1:0]    instr_addr,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [REG_AW-1:0]  addr1,
    output logic [REG_AW-1:0]  addr2,
    output logic [REG_AW-1:0]  addrdest,
    output logic               reg_we,
    output logic               wb_sel,
    output logic [2:0]         alu_ctrl,
    input  logic [1:0]         status,
    output logic               mem_req,
    output logic               mem_rnw,
    input  logic               mem_ack,
    output logic               halted,
    output logic               err
);

    if (DATA_W < 1 || INSTR_W != 16 || REG_CNT < 2 || REG_CNT > 16 || PC_W < 4 || PC_W > 8)
    begin : g_bad_params
        $error("steuerwerk_mc: parameter out of range");
    end

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [1:0]         flags_q, flags_d;
    logic               err_q, err_d;

    logic [3:0]         op;
    logic               in_instr;
    logic               waiting;
    logic               handshake;
    logic               expired;
    logic               unused_bits;

    assign op        = ir_q[OP_LSB +: 4];
    assign in_instr  = (state_q == DECODE) || (state_q == EXEC) ||
                       (state_q == MEM)    || (state_q == WB);
    assign waiting   = (state_q == FETCH) || (state_q == MEM);
    assign handshake = (state_q == FETCH) ? instr_valid : mem_ack;
    assign unused_bits = ^{ir_q, flags_q[CARRY]};

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!waiting || handshake),
        .en_i      (waiting && !handshake),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        err_d     = err_q;
        instr_req = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        mem_req   = 1'b0;
        mem_rnw   = 1'b0;

        unique case (state_q)
            FETCH: begin
                // Held low while reset is asserted so no fetch is advertised.
                instr_req = !rst;
                if (instr_valid) begin
                    ir_d    = instr_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = DECODE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (is_alu(op)) begin
                    flags_d = status;
                    state_d = WB;
                end else begin
                    case (op)
                        OP_LD, OP_ST: state_d = MEM;
                        OP_BZ: begin
                            if (flags_q[ZERO]) begin
                                pc_d = ir_q[PC_W-1:0];
                            end
                            state_d = FETCH;
                        end
                        OP_JMP: begin
                            pc_d    = ir_q[PC_W-1:0];
                            state_d = FETCH;
                        end
                        OP_HALT: state_d = HALT;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_rnw = (op == OP_LD);
                if (mem_ack) begin
                    state_d = (op == OP_LD) ? WB : FETCH;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            WB: begin
                reg_we  = 1'b1;
                wb_sel  = (op == OP_LD);
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Register addresses and ALU control follow the latched instruction
    // from DECODE until the instruction retires.
    assign addr1      = in_instr ? ir_q[RS1_LSB +: REG_AW] : '0;
    assign addr2      = in_instr ? ir_q[RS2_LSB +: REG_AW] : '0;
    assign addrdest   = in_instr ? ir_q[RD_LSB +: REG_AW]  : '0;
    assign alu_ctrl   = (in_instr && is_alu(op)) ? op[2:0] : 3'd0;
    assign instr_addr = pc_q;
    assign halted     = (state_q == HALT);
    assign err        = err_q;

endmodule

// File: tb/tb_steuerwerk_mc.sv
// tb/tb_steuerwerk_mc.sv - scoreboard testbench for steuerwerk_mc
module tb_steuerwerk_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = '0;
    logic [2:0]  addr1, addr2, addrdest;
    logic        reg_we, wb_sel;
    logic [2:0]  alu_ctrl;
    logic [1:0]  status = 2'b00;
    logic        mem_req, mem_rnw;
    logic        mem_ack = 1'b0;
    logic        halted, err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc, mcyc;

    logic [7:0]  exp_fetch[$];
    logic [12:0] exp_wb[$];   // {addrdest, addr1, addr2, wb_sel, alu_ctrl}
    logic [6:0]  exp_mem[$];  // {addr1, addr2, mem_rnw}

    steuerwerk_mc dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .addr1(addr1), .addr2(addr2), .addrdest(addrdest),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_ctrl(alu_ctrl), .status(status),
        .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_ack(mem_ack),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected response whenever the DUT completes a handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_req && instr_valid) begin
                chk("fetch_pending", 32'(exp_fetch.size() != 0), 32'd1);
                if (exp_fetch.size() != 0) chk("fetch_addr", 32'(instr_addr), 32'(exp_fetch.pop_front()));
            end
            if (reg_we) begin
                chk("wb_pending", 32'(exp_wb.size() != 0), 32'd1);
                if (exp_wb.size() != 0)
                    chk("wb_fields", 32'({addrdest, addr1, addr2, wb_sel, alu_ctrl}), 32'(exp_wb.pop_front()));
            end
            if (mem_req && mem_ack) begin
                chk("mem_pending", 32'(exp_mem.size() != 0), 32'd1);
                if (exp_mem.size() != 0)
                    chk("mem_fields", 32'({addr1, addr2, mem_rnw}), 32'(exp_mem.pop_front()));
            end
        end
    end

    // Issues one instruction starting in FETCH; returns its latency in cycles
    // and the number of cycles mem_req was high.
    task automatic run(input logic [15:0] w, input int vdly, input int adly,
                       input logic [1:0] st, output int c, output int mc);
        int m;
        status = st;
        c = 0;
        mc = 0;
        m = 0;
        for (int i = 0; i < vdly; i++) begin
            instr_valid = 1'b0;
            tick;
            c++;
        end
        instr_valid = 1'b1;
        instr_data  = w;
        tick;
        c++;
        instr_valid = 1'b0;
        while (!instr_req && !halted && c < 100) begin
            if (mem_req) begin
                mem_ack = (m == adly);
                m++;
                mc++;
            end else begin
                mem_ack = 1'b0;
            end
            tick;
            c++;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        tick;
        chk("rst_instr_req", 32'(instr_req), 32'd0);
        chk("rst_strobes", 32'({reg_we, mem_req, halted, err, wb_sel}), 32'd0);
        chk("rst_addrs", 32'({addr1, addr2, addrdest, alu_ctrl}), 32'd0);
        chk("rst_pc", 32'(instr_addr), 32'd0);
        rst = 1'b0;

        // ALU op 3, rd 2, rs1 1, rs2 0
        exp_fetch.push_back(8'h00);
        exp_wb.push_back({3'd2, 3'd1, 3'd0, 1'b0, 3'd3});
        run(16'h3210, 0, 0, 2'b00, cyc, mcyc);
        chk("alu_latency", 32'(cyc), 32'd4);
        chk("alu_pc", 32'(instr_addr), 32'h01);

        // LD rd 5 <- M[r4], ack delayed 3 cycles
        exp_fetch.push_back(8'h01);
        exp_mem.push_back({3'd4, 3'd0, 1'b1});
        exp_wb.push_back({3'd5, 3'd4, 3'd0, 1'b1, 3'd0});
        run(16'h8540, 0, 3, 2'b00, cyc, mcyc);
        chk("ld_latency", 32'(cyc), 32'd8);
        chk("ld_memreq_cycles", 32'(mcyc), 32'd4);

        // ST M[r3] <- r6, zero wait
        exp_fetch.push_back(8'h02);
        exp_mem.push_back({3'd3, 3'd6, 1'b0});
        run(16'h9036, 0, 0, 2'b00, cyc, mcyc);
        chk("st_latency", 32'(cyc), 32'd4);
        chk("st_pc", 32'(instr_addr), 32'h03);

        // ALU sets zero flag, BZ taken
        exp_fetch.push_back(8'h03);
        exp_wb.push_back({3'd1, 3'd2, 3'd3, 1'b0, 3'd1});
        run(16'h1123, 0, 0, 2'b01, cyc, mcyc);
        exp_fetch.push_back(8'h04);
        run(16'hA040, 0, 0, 2'b00, cyc, mcyc);
        chk("bz_latency", 32'(cyc), 32'd3);
        chk("bz_taken_pc", 32'(instr_addr), 32'h40);

        // ALU clears zero flag, BZ not taken
        exp_fetch.push_back(8'h40);
        exp_wb.push_back({3'd7, 3'd0, 3'd1, 1'b0, 3'd0});
        run(16'h0701, 0, 0, 2'b00, cyc, mcyc);
        exp_fetch.push_back(8'h41);
        run(16'hA010, 0, 0, 2'b01, cyc, mcyc);
        chk("bz_not_taken_pc", 32'(instr_addr), 32'h42);

        // JMP to 0xFF, NOP there wraps pc to 0
        exp_fetch.push_back(8'h42);
        run(16'hB0FF, 0, 0, 2'b00, cyc, mcyc);
        chk("jmp_pc", 32'(instr_addr), 32'hFF);
        exp_fetch.push_back(8'hFF);
        run(16'hC000, 0, 0, 2'b00, cyc, mcyc);
        chk("nop_latency", 32'(cyc), 32'd3);
        chk("pc_wrap", 32'(instr_addr), 32'h00);

        // Valid in the 15th wait cycle is accepted
        exp_fetch.push_back(8'h00);
        run(16'hD000, 14, 0, 2'b00, cyc, mcyc);
        chk("late_valid_latency", 32'(cyc), 32'd17);
        chk("late_valid_state", 32'({halted, err}), 32'd0);

        // HALT instruction: stops without error, pc frozen
        exp_fetch.push_back(8'h01);
        run(16'hF000, 0, 0, 2'b00, cyc, mcyc);
        chk("halt_latency", 32'(cyc), 32'd3);
        chk("halt_state", 32'({halted, err}), 32'b10);
        instr_valid = 1'b1;
        tick;
        tick;
        instr_valid = 1'b0;
        chk("halt_stays", 32'({halted, instr_req, instr_addr}), 32'({1'b1, 1'b0, 8'h02}));

        // Reset during a MEM stall
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_fetch.push_back(8'h00);
        instr_valid = 1'b1;
        instr_data  = 16'h8210;
        tick;
        instr_valid = 1'b0;
        tick;
        tick;
        chk("mem_stall_req", 32'(mem_req), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        chk("rst_mid_mem", 32'({mem_req, reg_we, instr_addr}), 32'd0);
        chk("rst_mid_halted", 32'({halted, err}), 32'd0);
        rst = 1'b0;

        // Fetch timeout: valid never arrives
        for (int i = 0; i < 14; i++) tick;
        chk("timeout_edge", 32'({halted, err, instr_req}), 32'b001);
        tick;
        chk("timeout_halt", 32'({halted, err, instr_req}), 32'b110);

        tick;
        chk("fetch_q_empty", 32'(exp_fetch.size()), 32'd0);
        chk("wb_q_empty", 32'(exp_wb.size()), 32'd0);
        chk("mem_q_empty", 32'(exp_mem.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
